// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data-memory responder.
// Holds the FSM state encodings, word width and address-to-index width helper.
package dmem_pkg;

   localparam int WORD_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage: synchronous write, registered read, no reset.
// One-cycle read latency; the read register only updates when i_re is high.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = idx_w(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [WORD_W-1:0] i_wdat,
   output logic [WORD_W-1:0] o_rdat
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_idx] <= i_wdat;
      if (i_re) o_rdat <= r_mem[i_idx];
   end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data memory with WAIT_CYCLES stall cycles per access; memStall holds the pipeline, ack pulses on completion.
// Optional one-entry read buffer (DMEM_READ_BUFFER_EN) completes repeated reads of the same word with no stall.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        memStall,
   output logic        ack,
   output logic        errFlag
);

   localparam int IDX_W = idx_w(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0);

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_op_wr;
   logic [IDX_W-1:0]  r_idx;
   logic [31:0]       r_wdat;
   logic              r_err;
   logic              r_rd_vld;

   logic              w_req;
   logic              w_hit;
   logic              w_accept;
   logic              w_commit;
   logic              w_live;
   logic              w_op_wr;
   logic [IDX_W-1:0]  w_idx_in;
   logic [IDX_W-1:0]  w_c_idx;
   logic [31:0]       w_c_wdat;
   logic [31:0]       w_arr_rdat;
   logic              w_unused_addr;

   assign w_req         = memRead | memWrite;
   assign w_idx_in      = addr[IDX_W+1:2];
   assign w_unused_addr = ^addr[31:IDX_W+2];

   // Acceptance and wait-1 commit use the live inputs; later commits use the latched copy.
   assign w_live   = (r_state == ST_IDLE);
   assign w_op_wr  = w_live ? memWrite : r_op_wr;
   assign w_c_idx  = w_live ? w_idx_in : r_idx;
   assign w_c_wdat = w_live ? wdata    : r_wdat;

   assign w_accept = ~rst & (r_state == ST_IDLE) & w_req & ~w_hit;
   assign w_commit = ~rst & ((w_accept & (WAIT_CYCLES == 1)) |
                             ((r_state == ST_WAIT) & (r_cnt == '0)));

   assign memStall = ~rst & (((r_state == ST_IDLE) & w_req & ~w_hit) | (r_state == ST_WAIT));
   assign ack      = ~rst & ((r_state == ST_DONE) | w_hit);
   assign errFlag  = r_err;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk    (clk),
      .i_we   (w_commit & w_op_wr),
      .i_re   (w_commit & ~w_op_wr),
      .i_idx  (w_c_idx),
      .i_wdat (w_c_wdat),
      .o_rdat (w_arr_rdat)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_op_wr  <= 1'b0;
         r_idx    <= '0;
         r_wdat   <= '0;
         r_err    <= 1'b0;
         r_rd_vld <= 1'b0;
      end else begin
         if ((w_accept | w_hit) & ((memRead & memWrite) | (addr[1:0] != 2'b00)))
            r_err <= 1'b1;
         if (w_commit & ~w_op_wr)
            r_rd_vld <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op_wr <= memWrite;
                  r_idx   <= w_idx_in;
                  r_wdat  <= wdata;
                  if (WAIT_CYCLES == 1) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_cnt   <= CNT_LOAD;
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) r_state <= ST_DONE;
               else             r_cnt   <= r_cnt - 1'b1;
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef DMEM_READ_BUFFER_EN
   logic              r_buf_vld;
   logic [IDX_W-1:0]  r_buf_idx;
   logic [31:0]       r_buf_dat;
   logic              r_rd_buf;

   assign w_hit = ~rst & (r_state == ST_IDLE) & memRead & ~memWrite &
                  r_buf_vld & (r_buf_idx == w_idx_in);

   // Buffer is filled in DONE, once the registered array read is visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_vld <= 1'b0;
         r_buf_idx <= '0;
         r_buf_dat <= '0;
         r_rd_buf  <= 1'b0;
      end else begin
         if ((r_state == ST_DONE) & ~r_op_wr) begin
            r_buf_vld <= 1'b1;
            r_buf_idx <= r_idx;
            r_buf_dat <= w_arr_rdat;
         end else if (w_commit & w_op_wr & (w_c_idx == r_buf_idx)) begin
            r_buf_vld <= 1'b0;
         end
         if (w_hit)                   r_rd_buf <= 1'b1;
         else if (w_commit & ~w_op_wr) r_rd_buf <= 1'b0;
      end
   end

   assign rdata = r_rd_buf ? r_buf_dat : (r_rd_vld ? w_arr_rdat : '0);
`else
   assign w_hit = 1'b0;
   assign rdata = r_rd_vld ? w_arr_rdat : '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stall/ack timing, data, wrap, misalign, dual request, reset abort, read buffer.
module tb_dmem_responder;

   localparam int W = 2;
`ifdef DMEM_READ_BUFFER_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        memRead, memWrite;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        memStall, ack, errFlag;

   int npass  = 0;
   int ntotal = 0;

   dmem_responder #(
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (W),
      .CNT_W       (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .memRead  (memRead),
      .memWrite (memWrite),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .memStall (memStall),
      .ack      (ack),
      .errFlag  (errFlag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Holds a request until ack, counting stall cycles before it; returns at posedge+1 with inputs dropped.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         output int stalls, output int ack_cyc,
                         output logic [31:0] rd_at_ack, output logic stall_at_ack);
      stalls = 0; ack_cyc = -1; rd_at_ack = 'x; stall_at_ack = 1'bx;
      memRead = rd; memWrite = wr; addr = a; wdata = wd;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (ack) begin
            ack_cyc = c; rd_at_ack = rdata; stall_at_ack = memStall;
            break;
         end
         if (memStall) stalls++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      memRead = 1'b0; memWrite = 1'b0;
   endtask

   task automatic run(input string tag, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int exp_stalls, output logic [31:0] rd_at_ack);
      int st, ac;
      logic sa;
      access(rd, wr, a, wd, st, ac, rd_at_ack, sa);
      chk({tag, "_stalls"}, st, exp_stalls);
      chk({tag, "_ack_cycle"}, ac, exp_stalls);
      chk({tag, "_stall_at_ack"}, {31'b0, sa}, 32'd0);
      @(negedge clk);
      chk({tag, "_ack_one_cycle"}, {31'b0, ack}, 32'd0);
      @(posedge clk); #1;
   endtask

   logic [31:0] rv;

   initial begin
      rst = 1'b1; memRead = 1'b0; memWrite = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_stall", {31'b0, memStall}, 32'd0);
      chk("rst_ack",   {31'b0, ack},      32'd0);
      chk("rst_rdata", rdata,             32'd0);
      chk("rst_err",   {31'b0, errFlag},  32'd0);
      @(posedge clk); #1;

      run("wr10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, W, rv);
      chk("wr10_rdata_unchanged", rdata, 32'd0);
      run("rd10", 1'b1, 1'b0, 32'h10, 32'h0, W, rv);
      chk("rd10_data", rv, 32'hDEADBEEF);

      run("wr1000", 1'b0, 1'b1, 32'h1000, 32'h1234, W, rv);
      run("rd0", 1'b1, 1'b0, 32'h0, 32'h0, W, rv);
      chk("wrap_data", rv, 32'h1234);
      chk("wrap_err", {31'b0, errFlag}, 32'd0);

      run("rd3", 1'b1, 1'b0, 32'h3, 32'h0, W, rv);
      chk("misalign_data", rv, 32'h1234);
      chk("misalign_err", {31'b0, errFlag}, 32'd1);

      run("both8", 1'b1, 1'b1, 32'h8, 32'h55, W, rv);
      chk("both8_rdata_held", rdata, 32'h1234);
      run("rd8", 1'b1, 1'b0, 32'h8, 32'h0, W, rv);
      chk("both8_data", rv, 32'h55);
      chk("err_sticky", {31'b0, errFlag}, 32'd1);

      run("wr40", 1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, W, rv);
      run("rd40a", 1'b1, 1'b0, 32'h40, 32'h0, W, rv);
      chk("rd40a_data", rv, 32'hA5A5A5A5);
      run("rd40b", 1'b1, 1'b0, 32'h40, 32'h0, BUF_EN ? 0 : W, rv);
      chk("rd40b_rdata", rdata, 32'hA5A5A5A5);
      run("wr40b", 1'b0, 1'b1, 32'h40, 32'h77, W, rv);
      run("rd40c", 1'b1, 1'b0, 32'h40, 32'h0, W, rv);
      chk("rd40c_data", rv, 32'h77);

      run("wr20", 1'b0, 1'b1, 32'h20, 32'h1111, W, rv);
      memWrite = 1'b1; addr = 32'h20; wdata = 32'h2222;
      @(negedge clk);
      chk("abort_accept_stall", {31'b0, memStall}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_stall", {31'b0, memStall}, 32'd0);
      chk("abort_ack",   {31'b0, ack},      32'd0);
      memWrite = 1'b0;
      @(negedge clk);
      chk("abort_ack_later", {31'b0, ack}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_idle_stall", {31'b0, memStall}, 32'd0);
      chk("abort_idle_ack",   {31'b0, ack},      32'd0);
      chk("abort_rdata",      rdata,             32'd0);
      chk("abort_err_clear",  {31'b0, errFlag},  32'd0);
      @(posedge clk); #1;
      run("rd20", 1'b1, 1'b0, 32'h20, 32'h0, W, rv);
      chk("abort_write_dropped", rv, 32'h1111);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
